note_seq_ctrl: RTL and testbench

Transport controller for the composer's note memory. It generates the beat tick internally and runs a record/erase/play state machine. It drives address, write-enable and data to a single-port note RAM, and tracks the song length. It sits between the key/switch front end and the RAM, replacing ad-hoc enable logic with one arbitrated sequencer.

---
 rtl/composer_pkg.sv | 22 ++
 rtl/beat_tick_gen.sv | 29 ++
 rtl/note_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_note_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/composer_pkg.sv
// Shared types and constants for the composer note sequencer.
// Holds the transport state encoding and the beat period helper.
package composer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        PLAY_RD,
        PLAY_HOLD
    } state_t;

    localparam int NOTE_W = 8;
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    localparam int DEF_CLK_HZ  = 5_000_000;
    localparam int DEF_BEAT_HZ = 2;

    function automatic int tick_period(input int clk_hz, input int beat_hz);
        return clk_hz / beat_hz;
    endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Free-running beat divider: one-cycle tick every TP cycles.
// A synchronous clear restarts the beat so the next tick is TP cycles away.
module beat_tick_gen #(
    parameter int TP = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(TP);
    localparam logic [CW-1:0] LAST = CW'(TP - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/note_seq_ctrl.sv
// Record/erase/play transport for the single-port note RAM.
// Define LOOP_PLAY_EN to wrap playback at the song end instead of stopping.
module note_seq_ctrl #(
    parameter int CLK_HZ  = composer_pkg::DEF_CLK_HZ,
    parameter int BEAT_HZ = composer_pkg::DEF_BEAT_HZ,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 7,
    parameter int NOTE_W  = composer_pkg::NOTE_W
) (
    input  logic              clk_5MHz,
    input  logic              resetn,
    input  logic              rec_req,
    input  logic              erase_req,
    input  logic              play_req,
    input  logic              stop_req,
    input  logic [NOTE_W-1:0] key_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [NOTE_W-1:0] mem_wdata,
    input  logic [NOTE_W-1:0] mem_rdata,
    output logic [NOTE_W-1:0] note_out,
    output logic [ADDR_W:0]   length,
    output logic              full,
    output logic              busy,
    output logic              play_done
);

    import composer_pkg::*;

    localparam int TP = tick_period(CLK_HZ, BEAT_HZ);
    localparam logic [ADDR_W:0] LEN_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [NOTE_W-1:0] REST = NOTE_W'(NOTE_REST);
`ifdef LOOP_PLAY_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_t r_state, w_next;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_ptr;
    logic [NOTE_W-1:0] r_note;
    logic              r_done, r_play_q, r_first;

    logic            w_tick, w_clr, w_play_edge, w_exit, w_last;
    logic            w_playing, w_done, w_wr_rec, w_wr_era;
    logic [ADDR_W:0] w_len_dec;

    assign w_play_edge = play_req && !r_play_q;
    assign w_exit      = stop_req || (LOOP_EN && !play_req);
    assign w_last      = ({1'b0, r_ptr} + 1'b1) == r_len;
    assign w_playing   = (r_state == PLAY_RD) || (r_state == PLAY_HOLD);
    assign w_len_dec   = r_len - 1'b1;
    assign w_clr       = (w_next != r_state);
    assign w_done      = (w_playing && w_exit) ||
                         (r_state == PLAY_HOLD && w_tick && w_last && !LOOP_EN);

    beat_tick_gen #(.TP(TP)) u_beat (
        .i_clk   (clk_5MHz),
        .i_rst_n (resetn),
        .i_clr   (w_clr),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk_5MHz or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (stop_req)                         w_next = IDLE;
                else if (w_play_edge && r_len != '0)  w_next = PLAY_RD;
                else if (rec_req && !full)            w_next = RECORD;
            end
            RECORD: begin
                if (!rec_req || stop_req || (w_tick && r_len == LEN_LAST))
                    w_next = IDLE;
            end
            PLAY_RD: w_next = w_exit ? IDLE : PLAY_HOLD;
            PLAY_HOLD: begin
                if (w_exit)      w_next = IDLE;
                else if (w_tick) w_next = (w_last && !LOOP_EN) ? IDLE : PLAY_RD;
            end
            default: w_next = IDLE;
        endcase
    end

    // Erase only wins in IDLE when no higher-priority request is pending.
    always_comb begin
        w_wr_rec  = 1'b0;
        w_wr_era  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = REST;
        unique case (r_state)
            IDLE: w_wr_era = w_tick && erase_req && r_len != '0 && !stop_req &&
                             !w_play_edge && !(rec_req && !full);
            RECORD:    w_wr_rec = w_tick && rec_req && !stop_req;
            PLAY_RD:   mem_addr = r_ptr;
            PLAY_HOLD: mem_addr = '0;
            default:   mem_addr = '0;
        endcase
        if (w_wr_rec) begin
            mem_we    = 1'b1;
            mem_addr  = r_len[ADDR_W-1:0];
            mem_wdata = key_in;
        end
        if (w_wr_era) begin
            mem_we   = 1'b1;
            mem_addr = w_len_dec[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk_5MHz or negedge resetn) begin
        if (!resetn) begin
            r_len    <= '0;
            r_ptr    <= '0;
            r_note   <= REST;
            r_done   <= 1'b0;
            r_play_q <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            r_play_q <= play_req;
            r_done   <= w_done;
            r_first  <= (r_state == PLAY_RD);
            if (w_wr_rec)      r_len <= r_len + 1'b1;
            else if (w_wr_era) r_len <= w_len_dec;
            if (r_state == IDLE)
                r_ptr <= '0;
            else if (r_state == PLAY_HOLD && w_tick && !w_exit)
                r_ptr <= w_last ? '0 : r_ptr + 1'b1;
            if (w_done)
                r_note <= REST;
            else if (r_state == PLAY_HOLD && r_first)
                r_note <= mem_rdata;
        end
    end

    assign note_out  = r_note;
    assign length    = r_len;
    assign full      = (r_len == LEN_MAX);
    assign busy      = (r_state != IDLE);
    assign play_done = r_done;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Bench for note_seq_ctrl: beat-timeline reference model plus directed
// and random stimulus against a small synchronous-read RAM.
module tb_note_seq_ctrl;

    localparam int TP = 4, DEP = 4, AW = 2, NW = 8, PER = TP + 1;
    localparam int LOGN = 1024;
    localparam int M_IDLE = 0, M_REC = 1, M_PLAY = 2;
`ifdef LOOP_PLAY_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clk = 1'b0, resetn = 1'b0;
    logic rec_req = 1'b0, erase_req = 1'b0, play_req = 1'b0, stop_req = 1'b0;
    logic [NW-1:0] key_in = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [NW-1:0] mem_wdata, mem_rdata, note_out;
    logic [AW:0]   length;
    logic          full, busy, play_done;

    logic [NW-1:0] ram [DEP] = '{default: 8'hEE};

    int total = 0, bad = 0, cyc = 0;

    int m_mode, m_age, m_len;
    bit m_done, m_pq;
    logic [NW-1:0] m_song [DEP];

    logic [NW-1:0] note_log [LOGN];
    bit done_log [LOGN];
    bit busy_log [LOGN];
    int wq_cyc[$], wq_addr[$], wq_data[$];

    note_seq_ctrl #(
        .CLK_HZ(8), .BEAT_HZ(2), .DEPTH(DEP), .ADDR_W(AW), .NOTE_W(NW)
    ) dut (
        .clk_5MHz  (clk),
        .resetn    (resetn),
        .rec_req   (rec_req),
        .erase_req (erase_req),
        .play_req  (play_req),
        .stop_req  (stop_req),
        .key_in    (key_in),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .note_out  (note_out),
        .length    (length),
        .full      (full),
        .busy      (busy),
        .play_done (play_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic mreset();
        m_mode = M_IDLE;
        m_age  = 0;
        m_len  = 0;
        m_done = 1'b0;
        m_pq   = 1'b0;
    endtask

    // One cycle: compare against the beat timeline, then advance it.
    task automatic step();
        int o, idx, nmode, eaddr;
        bit tk, edg, ndone, ewe;
        logic [NW-1:0] ewd, enote;
        @(negedge clk);
        if (!resetn) begin
            mreset();
        end else begin
            tk = (m_age % TP) == TP - 1;
            edg = play_req && !m_pq;
            o = m_age % PER;
            idx = m_age / PER;
            nmode = m_mode; ndone = 1'b0;
            ewe = 1'b0; eaddr = 0; ewd = '0; enote = '0;
            case (m_mode)
                M_IDLE: begin
                    if (stop_req) nmode = M_IDLE;
                    else if (edg && m_len > 0) nmode = M_PLAY;
                    else if (rec_req && m_len < DEP) nmode = M_REC;
                    else if (erase_req && m_len > 0 && tk) begin
                        ewe = 1'b1; eaddr = m_len - 1;
                    end
                end
                M_REC: begin
                    if (!rec_req || stop_req) nmode = M_IDLE;
                    else if (tk) begin
                        ewe = 1'b1; eaddr = m_len; ewd = key_in;
                        if (m_len + 1 == DEP) nmode = M_IDLE;
                    end
                end
                default: begin
                    if (o >= 2) enote = m_song[idx % m_len];
                    else if (idx > 0) enote = m_song[(idx - 1) % m_len];
                    if (o == 0) eaddr = idx % m_len;
                    if (stop_req || (LOOP && !play_req)) begin
                        nmode = M_IDLE; ndone = 1'b1;
                    end else if (o == TP && !LOOP && idx == m_len - 1) begin
                        nmode = M_IDLE; ndone = 1'b1;
                    end
                end
            endcase
            chk("we", mem_we, ewe);
            chk("addr", mem_addr, eaddr);
            chk("wdata", mem_wdata, ewd);
            chk("note", note_out, enote);
            chk("len", length, m_len);
            chk("full", full, m_len == DEP);
            chk("busy", busy, m_mode != M_IDLE);
            chk("done", play_done, m_done);
            if (ewe && m_mode == M_REC) begin
                m_song[m_len] = key_in; m_len++;
            end else if (ewe) begin
                m_len--;
            end
            m_done = ndone;
            m_age = (nmode != m_mode) ? 0 : m_age + 1;
            m_mode = nmode;
            m_pq = play_req;
        end
        if (cyc < LOGN) begin
            note_log[cyc] = note_out;
            done_log[cyc] = play_done;
            busy_log[cyc] = busy;
        end
        if (mem_we) begin
            wq_cyc.push_back(cyc);
            wq_addr.push_back(int'(mem_addr));
            wq_data.push_back(int'(mem_wdata));
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, ws, nd, sel, hold;
        mreset();
        step();
        step();
        chk("rst_len", length, 0);
        chk("rst_busy", busy, 0);
        chk("rst_note", note_out, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_done", play_done, 0);
        resetn = 1'b1;
        step();

        // record two notes
        ws = wq_cyc.size(); base = cyc; rec_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            key_in = (i <= 4) ? 8'h11 : 8'h22;
            step();
        end
        rec_req = 1'b0;
        step(); step();
        chk("rec_nwr", wq_cyc.size() - ws, 2);
        if (wq_cyc.size() >= ws + 2) begin
            chk("rec_w0_cyc", wq_cyc[ws], base + 4);
            chk("rec_w0_addr", wq_addr[ws], 0);
            chk("rec_w0_data", wq_data[ws], 'h11);
            chk("rec_w1_cyc", wq_cyc[ws+1], base + 8);
            chk("rec_w1_addr", wq_addr[ws+1], 1);
            chk("rec_w1_data", wq_data[ws+1], 'h22);
        end
        chk("rec_len", length, 2);

        // play the song
        base = cyc; play_req = 1'b1;
        for (int i = 0; i < 16; i++) step();
        chk("play_n0", note_log[base+3], 'h11);
        chk("play_n1", note_log[base+8], 'h22);
        nd = 0;
        for (int i = 0; i < 16; i++) nd += int'(done_log[base+i]);
`ifdef LOOP_PLAY_EN
        chk("loop_n2", note_log[base+13], 'h11);
        chk("loop_ndone", nd, 0);
`else
        chk("play_done_at", done_log[base+11], 1);
        chk("play_note_end", note_log[base+11], 0);
        chk("play_ndone", nd, 1);
`endif
        chk("play_len", length, 2);
        play_req = 1'b0;
        step(); step();

        // stop in the middle of playback
        base = cyc; play_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stop_req = (i == 4);
            step();
        end
        stop_req = 1'b0; play_req = 1'b0;
        step();
        chk("stop_busy_pre", busy_log[base+4], 1);
        chk("stop_note_pre", note_log[base+4], 'h11);
        chk("stop_busy", busy_log[base+5], 0);
        chk("stop_done", done_log[base+5], 1);
        chk("stop_note", note_log[base+5], 0);
        chk("stop_done_1cyc", done_log[base+6], 0);

        // erase two notes, third beat does nothing
        ws = wq_cyc.size(); erase_req = 1'b1;
        for (int i = 0; i < 14; i++) step();
        erase_req = 1'b0;
        step();
        chk("era_nwr", wq_cyc.size() - ws, 2);
        if (wq_cyc.size() >= ws + 2) begin
            chk("era_w0_addr", wq_addr[ws], 1);
            chk("era_w0_data", wq_data[ws], 0);
            chk("era_w1_addr", wq_addr[ws+1], 0);
            chk("era_w1_data", wq_data[ws+1], 0);
        end
        chk("era_len", length, 0);

        // fill the RAM with five beats of record
        ws = wq_cyc.size(); rec_req = 1'b1;
        for (int i = 0; i < 22; i++) begin
            key_in = NW'($urandom_range(1, 255));
            step();
        end
        rec_req = 1'b0;
        step();
        chk("full_nwr", wq_cyc.size() - ws, 4);
        for (int i = 0; i < 4 && ws + i < wq_cyc.size(); i++)
            chk("full_addr", wq_addr[ws+i], i);
        chk("full_flag", full, 1);
        chk("full_len", length, 4);
        chk("full_busy", busy, 0);

        // random traffic
        hold = 0; sel = 5;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                sel = $urandom_range(0, 5);
                hold = $urandom_range(4, 40);
            end
            rec_req   = (sel == 0 || sel == 1);
            erase_req = (sel == 2);
            play_req  = (sel == 3 || sel == 4);
            stop_req  = ($urandom_range(0, 49) == 0);
            key_in    = NW'($urandom_range(1, 255));
            hold--;
            step();
        end
        rec_req = 1'b0; erase_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
        step();

        // asynchronous reset in the middle of a recording
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        rec_req = 1'b1; key_in = 8'h5A;
        for (int i = 0; i < 6; i++) step();
        chk("ar_busy_pre", busy, 1);
        chk("ar_len_pre", length, 1);
        #2;
        resetn = 1'b0; rec_req = 1'b0; play_req = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_len", length, 0);
        chk("ar_we", mem_we, 0);
        chk("ar_addr", mem_addr, 0);
        chk("ar_note", note_out, 0);
        chk("ar_done", play_done, 0);
        step(); step();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("ar_noplay", busy, 0);
        play_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
